// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | unified_mem_arbiter: IF/MEM arbiter for one single-ported unified memory,   |
// | with data priority, fetch starvation guard, timeout and optional perf       |
// | counters (macro ARB_PERF_CNT_EN). Revision 1.0                              |
// +-----------------------------------------------------------------------------+
module unified_mem_arbiter #(
  parameter int MAX_STREAK  = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        IReq,
  input  logic [31:0] IAddr,
  output logic [31:0] IRData,
  output logic        IReady,
  input  logic        DReq,
  input  logic        DWe,
  input  logic [31:0] DAddr,
  input  logic [31:0] DWData,
  output logic [31:0] DRData,
  output logic        DReady,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  input  logic [31:0] MemRData,
  input  logic        MemAck,
  output logic        IStall,
  output logic        DStall,
  output logic        BusErr,
  output logic [31:0] IGrantCnt,
  output logic [31:0] DGrantCnt,
  output logic [31:0] ConflictCnt
);

  localparam int c_SW = $clog2(MAX_STREAK + 1);
  localparam int c_TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_SW-1:0] c_MAX_STREAK = c_SW'(MAX_STREAK);
  localparam logic [c_TW-1:0] c_TO_LAST    = c_TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY_I = 2'd1,
    S_BUSY_D = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t          r_state;
  logic [c_SW-1:0] r_streak;
  logic [c_TW-1:0] r_to_cnt;
  logic            w_idle;
  logic            w_grant_d;
  logic            w_grant_i;

  // Data wins unless fetch has already been passed over MAX_STREAK times.
  assign w_idle    = (r_state == S_IDLE);
  assign w_grant_d = w_idle && DReq && ((r_streak < c_MAX_STREAK) || !IReq);
  assign w_grant_i = w_idle && IReq && !w_grant_d;

  assign IStall = IReq & ~IReady;
  assign DStall = DReq & ~DReady;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state  <= S_IDLE;
      r_streak <= '0;
      r_to_cnt <= '0;
      MemReq   <= 1'b0;
      MemWe    <= 1'b0;
      MemAddr  <= 32'h0;
      MemWData <= 32'h0;
      IRData   <= 32'h0;
      DRData   <= 32'h0;
      IReady   <= 1'b0;
      DReady   <= 1'b0;
      BusErr   <= 1'b0;
    end else begin
      IReady <= 1'b0;
      DReady <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_d) begin
            r_state  <= S_BUSY_D;
            MemReq   <= 1'b1;
            MemWe    <= DWe;
            MemAddr  <= DAddr;
            MemWData <= DWData;
            r_to_cnt <= '0;
            if (!IReq)
              r_streak <= '0;
            else if (r_streak < c_MAX_STREAK)
              r_streak <= r_streak + 1'b1;
          end else if (w_grant_i) begin
            r_state  <= S_BUSY_I;
            MemReq   <= 1'b1;
            MemWe    <= 1'b0;
            MemAddr  <= IAddr;
            MemWData <= 32'h0;
            r_to_cnt <= '0;
            r_streak <= '0;
          end
        end
        S_BUSY_I, S_BUSY_D: begin
          // An ack on the timeout edge still completes normally.
          if (MemAck) begin
            MemReq  <= 1'b0;
            r_state <= S_RESP;
            if (r_state == S_BUSY_I) begin
              IRData <= MemRData;
              IReady <= 1'b1;
            end else begin
              if (!MemWe)
                DRData <= MemRData;
              DReady <= 1'b1;
            end
          end else if (r_to_cnt == c_TO_LAST) begin
            MemReq  <= 1'b0;
            BusErr  <= 1'b1;
            r_state <= S_RESP;
            if (r_state == S_BUSY_I) begin
              IRData <= 32'h0;
              IReady <= 1'b1;
            end else begin
              DRData <= 32'h0;
              DReady <= 1'b1;
            end
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] r_igrant_cnt;
  logic [31:0] r_dgrant_cnt;
  logic [31:0] r_conflict_cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_igrant_cnt   <= 32'h0;
      r_dgrant_cnt   <= 32'h0;
      r_conflict_cnt <= 32'h0;
    end else begin
      if (w_grant_i)
        r_igrant_cnt <= r_igrant_cnt + 32'd1;
      if (w_grant_d)
        r_dgrant_cnt <= r_dgrant_cnt + 32'd1;
      if (w_idle && IReq && DReq)
        r_conflict_cnt <= r_conflict_cnt + 32'd1;
    end
  end

  assign IGrantCnt   = r_igrant_cnt;
  assign DGrantCnt   = r_dgrant_cnt;
  assign ConflictCnt = r_conflict_cnt;
`else
  assign IGrantCnt   = 32'h0;
  assign DGrantCnt   = 32'h0;
  assign ConflictCnt = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_unified_mem_arbiter: scoreboard bench for unified_mem_arbiter.           |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
module tb_unified_mem_arbiter;

  localparam int c_TIMEOUT = 16;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        IReq = 1'b0;
  logic [31:0] IAddr = 32'h0;
  logic [31:0] IRData;
  logic        IReady;
  logic        DReq = 1'b0;
  logic        DWe = 1'b0;
  logic [31:0] DAddr = 32'h0;
  logic [31:0] DWData = 32'h0;
  logic [31:0] DRData;
  logic        DReady;
  logic        MemReq;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic [31:0] MemRData;
  logic        MemAck;
  logic        IStall;
  logic        DStall;
  logic        BusErr;
  logic [31:0] IGrantCnt;
  logic [31:0] DGrantCnt;
  logic [31:0] ConflictCnt;

  unified_mem_arbiter #(.MAX_STREAK(4), .TIMEOUT_CYC(c_TIMEOUT)) dut (
    .Clk(Clk), .Reset(Reset),
    .IReq(IReq), .IAddr(IAddr), .IRData(IRData), .IReady(IReady),
    .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWData(DWData),
    .DRData(DRData), .DReady(DReady),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData), .MemAck(MemAck),
    .IStall(IStall), .DStall(DStall), .BusErr(BusErr),
    .IGrantCnt(IGrantCnt), .DGrantCnt(DGrantCnt), .ConflictCnt(ConflictCnt)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic        is_d;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } grant_t;

  typedef struct packed {
    logic        is_d;
    logic [31:0] rdata;
    logic        buserr;
  } resp_t;

  grant_t gq[$];
  resp_t  rq[$];

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] m_irdata = 32'h0;
  logic [31:0] m_drdata = 32'h0;
  logic        m_buserr = 1'b0;
  int m_ig = 0, m_dg = 0, m_cf = 0;

  int ack_lat = 1;
  bit spur = 1'b0;
  int busy_seen = 0;
  int busy_len = 0, last_busy_len = 0;
  logic prev_memreq = 1'b0, prev_both = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a == 32'h40) ? 32'h1234_5678 : (a ^ 32'h5A5A_1234);
  endfunction

  // Memory responder: acks on the ack_lat-th cycle of MemReq (0 = never).
  initial begin
    MemAck = 1'b0;
    MemRData = 32'hDEAD_BEEF;
    forever begin
      @(posedge Clk); #1;
      MemAck = 1'b0;
      MemRData = 32'hDEAD_BEEF;
      if (MemReq) busy_seen++; else busy_seen = 0;
      if (MemReq && ack_lat > 0 && busy_seen == ack_lat) begin
        MemAck = 1'b1;
        MemRData = memf(MemAddr);
      end
      if (spur) begin
        MemAck = 1'b1;
        spur = 1'b0;
      end
    end
  end

  // Monitor: grants on MemReq rising, responses on Ready pulses.
  initial begin
    grant_t g;
    resp_t  r;
    forever begin
      @(negedge Clk);
      if (MemReq && !prev_memreq) begin
        if (gq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_grant: MemAddr=%h with empty grant queue", MemAddr);
        end else begin
          g = gq.pop_front();
          chk("grant_addr", MemAddr, g.addr);
          chk("grant_we", {31'h0, MemWe}, {31'h0, g.we});
          if (g.we) chk("grant_wdata", MemWData, g.wdata);
          if (g.is_d) m_dg++; else m_ig++;
          if (prev_both) m_cf++;
        end
      end
      if (MemReq) busy_len++;
      else if (prev_memreq) begin
        last_busy_len = busy_len;
        busy_len = 0;
      end
      if (IReady || DReady) begin
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ready: IReady=%b DReady=%b with empty scoreboard", IReady, DReady);
        end else begin
          r = rq.pop_front();
          chk("resp_kind_dready", {31'h0, DReady}, {31'h0, r.is_d});
          chk("resp_kind_iready", {31'h0, IReady}, {31'h0, ~r.is_d});
          chk("resp_rdata", r.is_d ? DRData : IRData, r.rdata);
          chk("resp_buserr", {31'h0, BusErr}, {31'h0, r.buserr});
        end
      end
      prev_memreq = MemReq;
      prev_both = IReq & DReq;
    end
  end

  task automatic expect_access(input bit is_d, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata, input int lat);
    grant_t g;
    resp_t  r;
    bit to;
    to = (lat == 0) || (lat > c_TIMEOUT);
    g.is_d = is_d; g.addr = addr; g.we = is_d & we; g.wdata = wdata;
    r.is_d = is_d;
    r.buserr = m_buserr | to;
    if (to) r.rdata = 32'h0;
    else if (is_d && we) r.rdata = m_drdata;
    else r.rdata = memf(addr);
    if (is_d) m_drdata = r.rdata; else m_irdata = r.rdata;
    m_buserr = r.buserr;
    gq.push_back(g);
    rq.push_back(r);
  endtask

  task automatic access(input bit is_d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int lat);
    int n;
    bit seen;
    expect_access(is_d, we, addr, wdata, lat);
    @(posedge Clk); #1;
    ack_lat = lat;
    if (is_d) begin DReq = 1; DWe = we; DAddr = addr; DWData = wdata; end
    else begin IReq = 1; IAddr = addr; end
    seen = 0;
    for (n = 0; n < 100 && !seen; n++) begin
      @(negedge Clk);
      seen = is_d ? DReady : IReady;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL access_ready_timeout: no Ready for addr %h within 100 cycles", addr);
    end
    @(posedge Clk); #1;
    IReq = 0; DReq = 0;
  endtask

  // Fetch with cycle-exact latency checks (Req sampled in IDLE at cycle 0).
  task automatic timed_fetch(input logic [31:0] addr);
    expect_access(0, 0, addr, 32'h0, 1);
    @(posedge Clk); #1;
    ack_lat = 1; IReq = 1; IAddr = addr;
    @(negedge Clk);
    chk("fetch_c0_memreq", {31'h0, MemReq}, 32'h0);
    chk("fetch_c0_istall", {31'h0, IStall}, 32'h1);
    @(negedge Clk);
    chk("fetch_c1_memreq", {31'h0, MemReq}, 32'h1);
    chk("fetch_c1_iready", {31'h0, IReady}, 32'h0);
    @(negedge Clk);
    chk("fetch_c2_iready", {31'h0, IReady}, 32'h1);
    chk("fetch_c2_istall", {31'h0, IStall}, 32'h0);
    chk("fetch_c2_memreq", {31'h0, MemReq}, 32'h0);
    @(posedge Clk); #1;
    IReq = 0;
    @(negedge Clk);
    chk("fetch_c3_iready", {31'h0, IReady}, 32'h0);
  endtask

  task automatic chk_perf();
`ifdef ARB_PERF_CNT_EN
    chk("perf_igrant", IGrantCnt, m_ig);
    chk("perf_dgrant", DGrantCnt, m_dg);
    chk("perf_conflict", ConflictCnt, m_cf);
`else
    chk("perf_igrant_tied", IGrantCnt, 32'h0);
    chk("perf_dgrant_tied", DGrantCnt, 32'h0);
    chk("perf_conflict_tied", ConflictCnt, 32'h0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nready, busy;
    repeat (3) @(posedge Clk);
    #1 Reset = 0;
    @(negedge Clk);
    chk("rst_memreq", {31'h0, MemReq}, 32'h0);
    chk("rst_memwe", {31'h0, MemWe}, 32'h0);
    chk("rst_iready", {31'h0, IReady}, 32'h0);
    chk("rst_dready", {31'h0, DReady}, 32'h0);
    chk("rst_buserr", {31'h0, BusErr}, 32'h0);
    chk("rst_memaddr", MemAddr, 32'h0);
    chk("rst_memwdata", MemWData, 32'h0);
    chk("rst_irdata", IRData, 32'h0);
    chk("rst_drdata", DRData, 32'h0);

    timed_fetch(32'h40);
    chk("fetch_irdata", IRData, 32'h1234_5678);

    access(1, 0, 32'h200, 32'h0, 2);
    access(1, 1, 32'h100, 32'hCAFE_F00D, 1);
    chk("store_keeps_drdata", DRData, memf(32'h200));

    access(1, 0, 32'h204, 32'h0, c_TIMEOUT);
    chk("ack_on_timeout_busy_len", last_busy_len, c_TIMEOUT);
    chk("ack_on_timeout_no_err", {31'h0, BusErr}, 32'h0);

    // both requesters held high: expect D,D,D,D,I,D,D,D,D,I
    for (int i = 0; i < 10; i++)
      expect_access((i != 4) && (i != 9), 0, ((i != 4) && (i != 9)) ? 32'h400 : 32'h80, 32'h0, 1);
    @(posedge Clk); #1;
    ack_lat = 1; IReq = 1; IAddr = 32'h80; DReq = 1; DWe = 0; DAddr = 32'h400;
    nready = 0;
    for (n = 0; n < 200 && nready < 10; n++) begin
      @(negedge Clk);
      if (IReady) chk("streak_dstall_held", {31'h0, DStall}, 32'h1);
      if (IReady || DReady) nready++;
    end
    if (nready < 10) begin
      checks++; errors++;
      $display("FAIL streak_ready_count: got %0d readies expected 10", nready);
    end
    @(posedge Clk); #1;
    IReq = 0; DReq = 0;

    access(1, 0, 32'h208, 32'h0, 0);
    chk("timeout_busy_len", last_busy_len, c_TIMEOUT);
    chk("timeout_buserr", {31'h0, BusErr}, 32'h1);
    chk("timeout_memreq", {31'h0, MemReq}, 32'h0);
    access(0, 0, 32'h44, 32'h0, 3);
    chk("buserr_sticky", {31'h0, BusErr}, 32'h1);
    chk_perf();

    // reset on the 3rd BUSY_D cycle abandons the access
    begin
      grant_t g;
      g.is_d = 1; g.addr = 32'h300; g.we = 0; g.wdata = 32'h0;
      gq.push_back(g);
    end
    @(posedge Clk); #1;
    ack_lat = 0; DReq = 1; DWe = 0; DAddr = 32'h300;
    busy = 0;
    for (n = 0; n < 50 && busy < 3; n++) begin
      @(negedge Clk);
      if (MemReq) busy++;
    end
    if (busy < 3) begin
      checks++; errors++;
      $display("FAIL rst_busy_reach: got %0d BUSY cycles expected 3", busy);
    end
    Reset = 1; DReq = 0;
    @(posedge Clk); #1;
    Reset = 0;
    m_irdata = 0; m_drdata = 0; m_buserr = 0; m_ig = 0; m_dg = 0; m_cf = 0;
    @(negedge Clk);
    chk("rst_mid_memreq", {31'h0, MemReq}, 32'h0);
    chk("rst_mid_buserr", {31'h0, BusErr}, 32'h0);
    spur = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      chk("rst_mid_no_dready", {31'h0, DReady}, 32'h0);
      chk("rst_mid_idle_memreq", {31'h0, MemReq}, 32'h0);
    end
    chk("rst_mid_drdata", DRData, 32'h0);

    timed_fetch(32'h48);
    chk_perf();

    repeat (3) @(negedge Clk);
    chk("grant_queue_empty", gq.size(), 32'h0);
    chk("resp_queue_empty", rq.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
